prog_launcher: RTL

Sequencer directly upstream of the Top core. On one GO request it runs NUM_PROGS programs back-to-back on Top. For each program it drives PROG_ID, issues a fixed-width START pulse, and ignores a possibly stale DONE for a settle window. It then waits for DONE, reports the per-program cycle count, and flags ALL_DONE, or TIMEOUT if Top hangs.

---
 rtl/prog_launcher_if.sv | 28 ++
 rtl/prog_launcher.sv | 116 +++++++++++
 2 files changed

// File: rtl/prog_launcher_if.sv
// Control/status bundle between the program launcher and its requester/Top core.
// The slave side is the launcher; the master side drives GO and Top's DONE.
interface prog_launcher_if #(
  parameter int unsigned NUM_PROGS = 2,
  parameter int unsigned CNT_W     = 16
);
  localparam int unsigned PROG_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  logic              go;
  logic              done_in;
  logic              start;
  logic [PROG_W-1:0] prog_id;
  logic              busy;
  logic [CNT_W-1:0]  cyc_count;
  logic              cyc_valid;
  logic              all_done;
  logic              timeout;

  modport master (
    output go, done_in,
    input  start, prog_id, busy, cyc_count, cyc_valid, all_done, timeout
  );

  modport slave (
    input  go, done_in,
    output start, prog_id, busy, cyc_count, cyc_valid, all_done, timeout
  );
endinterface

// File: rtl/prog_launcher.sv
// Runs NUM_PROGS programs back-to-back on Top per GO: START pulse, stale-DONE
// settle window, DONE wait with timeout, and a per-program cycle-count report.
module prog_launcher #(
  parameter int unsigned NUM_PROGS      = 2,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  prog_launcher_if.slave  bus
);
  localparam int unsigned       PROG_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
  localparam logic [CNT_W-1:0]  PULSE_END   = CNT_W'(START_CYCLES);
  localparam logic [CNT_W-1:0]  SETTLE_END  = CNT_W'(START_CYCLES + SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PROG_W-1:0] LAST_PROG   = PROG_W'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    REPORT = 3'd4,
    FAULT  = 3'd5
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cyc_count_q;
  logic [PROG_W-1:0] prog_id_q;
  logic              start_q;
  logic              busy_q;
  logic              cyc_valid_q;
  logic              all_done_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Saturating increment; also the count that includes the current sampling edge.
  assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_count_q <= '0;
      prog_id_q   <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      cyc_valid_q <= 1'b0;
      all_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cyc_valid_q <= 1'b0;
      unique case (state_q)
        IDLE, FAULT: begin
          if (bus.go) begin
            state_q    <= PULSE;
            prog_id_q  <= '0;
            all_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= CNT_W'(1);
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        PULSE: begin
          cnt_q <= cnt_inc_c;
          if (cnt_q == PULSE_END) begin
            start_q <= 1'b0;
            state_q <= (SETTLE_CYCLES == 0) ? WAIT : SETTLE;
          end
        end
        SETTLE: begin
          // DONE_IN deliberately not looked at: Top may still hold the previous DONE.
          cnt_q <= cnt_inc_c;
          if (cnt_q == SETTLE_END) state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_inc_c;
          if (bus.done_in) begin
            state_q     <= REPORT;
            cyc_count_q <= cnt_inc_c;
            cyc_valid_q <= 1'b1;
          end else if (cnt_inc_c == TIMEOUT_CNT) begin
            state_q   <= FAULT;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        REPORT: begin
          if (prog_id_q == LAST_PROG) begin
            state_q    <= IDLE;
            all_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q   <= PULSE;
            prog_id_q <= prog_id_q + PROG_W'(1);
            cnt_q     <= CNT_W'(1);
            start_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.start     = start_q;
  assign bus.prog_id   = prog_id_q;
  assign bus.busy      = busy_q;
  assign bus.cyc_count = cyc_count_q;
  assign bus.cyc_valid = cyc_valid_q;
  assign bus.all_done  = all_done_q;
  assign bus.timeout   = timeout_q;
endmodule
